// File: rtl/pipelined_add_sub.sv
// pipelined_add_sub
// Purpose: N-bit adder/subtractor that breaks the carry chain into S chunks of
// N/S bits. Each chunk is resolved in its own pipeline stage. Stage k adds
// chunk k using the carry registered by stage k-1. The unused upper operand
// chunks and the already-resolved lower sum bits travel alongside each beat.
// One global stall freezes every stage while the output is held.
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset; clears all stage state
//   in_valid   operand beat present
//   in_ready   block accepts a beat this cycle (= !stall)
//   inA, inB   N-bit operands
//   cin        carry-in for add, borrow-in for subtract
//   sub        0 = add, 1 = subtract (A - B - cin)
//   out_valid  result beat present
//   out_ready  downstream accepts the result
//   sum        N-bit result
//   carry      carry-out; for subtract, 1 = no borrow
//   overflow   two's-complement signed overflow
module pipelined_add_sub #(
  parameter int N = 8,
  parameter int S = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] inA,
  input  logic [N-1:0] inB,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         carry,
  output logic         overflow
);

  localparam int C = N / S;

  logic         w_stall;
  logic [N-1:0] w_bEff;
  logic         w_cEff;

  // Subtraction is A + ~B + ~cin. The operand is inverted once at the input,
  // so every stage runs a plain adder.
  assign w_stall  = out_valid && !out_ready;
  assign in_ready = !w_stall;
  assign w_bEff   = sub ? ~inB : inB;
  assign w_cEff   = sub ? ~cin : cin;

  for (genvar k = 0; k < S; k++) begin : g_stage
    localparam int LO = k * C;
    localparam int HI = LO + C;

    // w_aUp/w_bUp hold the operand bits not yet consumed, starting at this
    // stage's chunk. w_newSum holds every sum bit resolved so far.
    logic          w_vIn;
    logic          w_cIn;
    logic [N-1:LO] w_aUp;
    logic [N-1:LO] w_bUp;
    logic [HI-1:0] w_newSum;
    logic [C:0]    w_chunk;

    logic          r_valid;
    logic          r_carry;
    logic [HI-1:0] r_sum;

    if (k == 0) begin : g_src
      assign w_vIn    = in_valid;
      assign w_cIn    = w_cEff;
      assign w_aUp    = inA;
      assign w_bUp    = w_bEff;
      assign w_newSum = w_chunk[C-1:0];
    end else begin : g_src
      assign w_vIn    = g_stage[k-1].r_valid;
      assign w_cIn    = g_stage[k-1].r_carry;
      assign w_aUp    = g_stage[k-1].g_hold.r_a;
      assign w_bUp    = g_stage[k-1].g_hold.r_b;
      assign w_newSum = {w_chunk[C-1:0], g_stage[k-1].r_sum};
    end

    assign w_chunk = {1'b0, w_aUp[LO +: C]} + {1'b0, w_bUp[LO +: C]}
                   + {{C{1'b0}}, w_cIn};

    // Clearing the data on reset keeps sum/carry at zero while rst_n is low.
    // The valid bit lets bubbles flow through the stages like normal beats.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_valid <= 1'b0;
        r_carry <= 1'b0;
        r_sum   <= '0;
      end else if (!w_stall) begin
        r_valid <= w_vIn;
        r_carry <= w_chunk[C];
        r_sum   <= w_newSum;
      end
    end

    if (k < S - 1) begin : g_hold
      logic [N-1:HI] r_a;
      logic [N-1:HI] r_b;

      // Only the operand chunks that later stages still need are carried.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (!w_stall) begin
          r_a <= w_aUp[N-1:HI];
          r_b <= w_bUp[N-1:HI];
        end
      end
    end else begin : g_last
      logic r_ovf;

      // Signed overflow occurs when both effective operands share a sign
      // and the resulting sum has the other sign.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_ovf <= 1'b0;
        end else if (!w_stall) begin
          r_ovf <= (w_aUp[N-1] == w_bUp[N-1]) && (w_newSum[N-1] != w_aUp[N-1]);
        end
      end
    end
  end

  assign out_valid = g_stage[S-1].r_valid;
  assign sum       = g_stage[S-1].r_sum;
  assign carry     = g_stage[S-1].r_carry;
  assign overflow  = g_stage[S-1].g_last.r_ovf;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// tb_pipelined_add_sub
// Purpose: self-checking bench for pipelined_add_sub. It drives two instances:
// an 8-bit, 2-stage instance and a 16-bit, 4-stage instance. Expected results
// come from an integer-arithmetic model of A+B+cin / A-B-cin.
module tb_pipelined_add_sub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       n8InValid, n8InReady, n8Cin, n8Sub, n8OutValid, n8OutReady;
  logic       n8Carry, n8Ovf;
  logic [7:0] n8A, n8B, n8Sum;

  logic        w16InValid, w16InReady, w16Cin, w16Sub, w16OutValid, w16OutReady;
  logic        w16Carry, w16Ovf;
  logic [15:0] w16A, w16B, w16Sum;

  int total = 0;
  int bad   = 0;

  pipelined_add_sub #(.N(8), .S(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(n8InValid), .in_ready(n8InReady),
    .inA(n8A), .inB(n8B), .cin(n8Cin), .sub(n8Sub), .out_valid(n8OutValid),
    .out_ready(n8OutReady), .sum(n8Sum), .carry(n8Carry), .overflow(n8Ovf)
  );

  pipelined_add_sub #(.N(16), .S(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(w16InValid), .in_ready(w16InReady),
    .inA(w16A), .inB(w16B), .cin(w16Cin), .sub(w16Sub), .out_valid(w16OutValid),
    .out_ready(w16OutReady), .sum(w16Sum), .carry(w16Carry), .overflow(w16Ovf)
  );

  // Reference: plain integer arithmetic. Returns {overflow, carry, sum[15:0]}.
  // For subtraction, carry means "no borrow", i.e. A - B - cin >= 0.
  function automatic logic [17:0] refModel(input int n, input int a, input int b,
                                           input logic c, input logic s);
    int ci, m, full, sa, sb, sr;
    logic [17:0] r;
    ci   = c ? 1 : 0;
    m    = 1 << n;
    full = s ? (a - b - ci) : (a + b + ci);
    sa   = (a >= m / 2) ? a - m : a;
    sb   = (b >= m / 2) ? b - m : b;
    sr   = s ? (sa - sb - ci) : (sa + sb + ci);
    r       = '0;
    r[15:0] = 16'(((full % m) + m) % m);
    r[16]   = s ? (full >= 0) : (full >= m);
    r[17]   = (sr >= m / 2) || (sr < -(m / 2));
    return r;
  endfunction

  // Drives one random beat on the 8-bit instance and returns its expected
  // {overflow, carry, sum}.
  task automatic applyStimulus(output logic [9:0] exp);
    logic [17:0] r;
    n8InValid = 1'b1;
    n8A       = 8'($urandom);
    n8B       = 8'($urandom);
    n8Cin     = 1'($urandom);
    n8Sub     = 1'($urandom);
    r   = refModel(8, int'(n8A), int'(n8B), n8Cin, n8Sub);
    exp = {r[17], r[16], r[7:0]};
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    n8InValid = 1'b0; n8A = '0; n8B = '0; n8Cin = 1'b0; n8Sub = 1'b0; n8OutReady = 1'b1;
    w16InValid = 1'b0; w16A = '0; w16B = '0; w16Cin = 1'b0; w16Sub = 1'b0; w16OutReady = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (n8OutValid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid: got %b want 0", n8OutValid); end
    total++;
    if ({n8Ovf, n8Carry, n8Sum} !== 10'h000) begin
      bad++; $display("[TB] FAIL reset_outputs: got ovf=%b carry=%b sum=%h want all 0", n8Ovf, n8Carry, n8Sum);
    end
    total++;
    if (n8InReady !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready: got %b want 1", n8InReady); end
    total++;
    if ({w16OutValid, w16Sum} !== 17'h0) begin
      bad++; $display("[TB] FAIL reset_wide: got valid=%b sum=%h want 0/0000", w16OutValid, w16Sum);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  localparam logic [7:0] DIR_A   [5] = '{8'hBA, 8'h7F, 8'h80, 8'h00, 8'h10};
  localparam logic [7:0] DIR_B   [5] = '{8'hEB, 8'h01, 8'h01, 8'h01, 8'h01};
  localparam logic       DIR_C   [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam logic       DIR_S   [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  localparam logic [7:0] DIR_SUM [5] = '{8'hA5, 8'h80, 8'h7F, 8'hFF, 8'h0E};
  localparam logic       DIR_CY  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  localparam logic       DIR_OV  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  task automatic test_directed();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n8InValid = 1'b1; n8A = DIR_A[i]; n8B = DIR_B[i]; n8Cin = DIR_C[i]; n8Sub = DIR_S[i];
      n8OutReady = 1'b1;
      @(negedge clk);
      n8InValid = 1'b0; n8A = 8'($urandom); n8B = 8'($urandom);
      total++;
      if (n8OutValid !== 1'b0) begin bad++; $display("[TB] FAIL dir%0d_early: out_valid=%b want 0", i, n8OutValid); end
      @(negedge clk);
      total++;
      if ({n8OutValid, n8Ovf, n8Carry, n8Sum} !== {1'b1, DIR_OV[i], DIR_CY[i], DIR_SUM[i]}) begin
        bad++;
        $display("[TB] FAIL dir%0d_result: got v=%b ovf=%b c=%b sum=%h want v=1 ovf=%b c=%b sum=%h",
                 i, n8OutValid, n8Ovf, n8Carry, n8Sum, DIR_OV[i], DIR_CY[i], DIR_SUM[i]);
      end
      @(negedge clk);
      total++;
      if (n8OutValid !== 1'b0) begin bad++; $display("[TB] FAIL dir%0d_dup: out_valid=%b want 0", i, n8OutValid); end
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp [4];
    for (int cyc = 0; cyc < 7; cyc++) begin
      @(negedge clk);
      n8OutReady = 1'b1;
      if (cyc < 4) applyStimulus(exp[cyc]);
      else n8InValid = 1'b0;
      #1;
      if (cyc < 4) begin
        total++;
        if (n8InReady !== 1'b1) begin bad++; $display("[TB] FAIL b2b_in_ready%0d: got %b want 1", cyc, n8InReady); end
      end
      total++;
      if (cyc >= 2 && cyc < 6) begin
        if ({n8OutValid, n8Ovf, n8Carry, n8Sum} !== {1'b1, exp[cyc-2]}) begin
          bad++;
          $display("[TB] FAIL b2b_out%0d: got v=%b {ovf,c,sum}=%h want v=1 %h",
                   cyc - 2, n8OutValid, {n8Ovf, n8Carry, n8Sum}, exp[cyc-2]);
        end
      end else if (n8OutValid !== 1'b0) begin
        bad++; $display("[TB] FAIL b2b_idle%0d: out_valid=%b want 0", cyc, n8OutValid);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [9:0] e0, e1, e2;
    @(negedge clk); n8OutReady = 1'b1; applyStimulus(e0);
    @(negedge clk); applyStimulus(e1);
    @(negedge clk);
    #1;
    total++;
    if ({n8OutValid, n8Ovf, n8Carry, n8Sum} !== {1'b1, e0}) begin
      bad++; $display("[TB] FAIL bp_first: got v=%b %h want v=1 %h", n8OutValid, {n8Ovf, n8Carry, n8Sum}, e0);
    end
    n8OutReady = 1'b0;
    applyStimulus(e2);
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if ({n8InReady, n8OutValid, n8Ovf, n8Carry, n8Sum} !== {1'b0, 1'b1, e0}) begin
        bad++;
        $display("[TB] FAIL bp_hold%0d: got rdy=%b v=%b %h want rdy=0 v=1 %h",
                 i, n8InReady, n8OutValid, {n8Ovf, n8Carry, n8Sum}, e0);
      end
      @(negedge clk);
    end
    n8OutReady = 1'b1;
    #1;
    total++;
    if (n8InReady !== 1'b1) begin bad++; $display("[TB] FAIL bp_release: in_ready=%b want 1", n8InReady); end
    @(negedge clk);
    n8InValid = 1'b0;
    total++;
    if ({n8OutValid, n8Ovf, n8Carry, n8Sum} !== {1'b1, e1}) begin
      bad++; $display("[TB] FAIL bp_second: got v=%b %h want v=1 %h", n8OutValid, {n8Ovf, n8Carry, n8Sum}, e1);
    end
    @(negedge clk);
    total++;
    if ({n8OutValid, n8Ovf, n8Carry, n8Sum} !== {1'b1, e2}) begin
      bad++; $display("[TB] FAIL bp_third: got v=%b %h want v=1 %h", n8OutValid, {n8Ovf, n8Carry, n8Sum}, e2);
    end
    @(negedge clk);
    total++;
    if (n8OutValid !== 1'b0) begin bad++; $display("[TB] FAIL bp_extra: out_valid=%b want 0", n8OutValid); end
  endtask

  task automatic test_reset_midstream();
    logic [9:0] e0, e1, ef;
    @(negedge clk); n8OutReady = 1'b1; applyStimulus(e0);
    @(negedge clk); applyStimulus(e1);
    #6;
    n8InValid = 1'b0;
    rst_n = 1'b0;
    #1;
    total++;
    if ({n8OutValid, n8Sum} !== 9'h000) begin
      bad++; $display("[TB] FAIL mid_reset_async: got v=%b sum=%h want 0/00", n8OutValid, n8Sum);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(ef);
    @(negedge clk);
    n8InValid = 1'b0;
    total++;
    if (n8OutValid !== 1'b0) begin bad++; $display("[TB] FAIL mid_stale: out_valid=%b want 0", n8OutValid); end
    @(negedge clk);
    total++;
    if ({n8OutValid, n8Ovf, n8Carry, n8Sum} !== {1'b1, ef}) begin
      bad++; $display("[TB] FAIL mid_first_beat: got v=%b %h want v=1 %h", n8OutValid, {n8Ovf, n8Carry, n8Sum}, ef);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (n8OutValid !== 1'b0) begin bad++; $display("[TB] FAIL mid_ghost%0d: out_valid=%b want 0", i, n8OutValid); end
    end
  endtask

  task automatic test_wide();
    logic [17:0] exp [8];
    logic [17:0] r;
    @(negedge clk);
    w16InValid = 1'b1; w16A = 16'h00BA; w16B = 16'h00EB; w16Cin = 1'b0; w16Sub = 1'b0; w16OutReady = 1'b1;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      w16InValid = 1'b0;
      total++;
      if (cyc < 4) begin
        if (w16OutValid !== 1'b0) begin bad++; $display("[TB] FAIL wide_early%0d: out_valid=%b want 0", cyc, w16OutValid); end
      end else if ({w16OutValid, w16Ovf, w16Carry, w16Sum} !== {1'b1, 1'b0, 1'b0, 16'h01A5}) begin
        bad++;
        $display("[TB] FAIL wide_dir: got v=%b ovf=%b c=%b sum=%h want v=1 ovf=0 c=0 sum=01a5",
                 w16OutValid, w16Ovf, w16Carry, w16Sum);
      end
    end
    for (int cyc = 0; cyc < 13; cyc++) begin
      @(negedge clk);
      if (cyc < 8) begin
        w16InValid = 1'b1;
        w16A = 16'($urandom); w16B = 16'($urandom); w16Cin = 1'($urandom); w16Sub = 1'($urandom);
        r = refModel(16, int'(w16A), int'(w16B), w16Cin, w16Sub);
        exp[cyc] = r;
      end else begin
        w16InValid = 1'b0;
      end
      #1;
      total++;
      if (cyc >= 4 && cyc < 12) begin
        if ({w16OutValid, w16Ovf, w16Carry, w16Sum} !== {1'b1, exp[cyc-4]}) begin
          bad++;
          $display("[TB] FAIL wide_stream%0d: got v=%b %h want v=1 %h",
                   cyc - 4, w16OutValid, {w16Ovf, w16Carry, w16Sum}, exp[cyc-4]);
        end
      end else if (w16OutValid !== 1'b0) begin
        bad++; $display("[TB] FAIL wide_idle%0d: out_valid=%b want 0", cyc, w16OutValid);
      end
    end
  endtask

  // Random traffic with random backpressure. A queue holds the expected
  // results in acceptance order.
  task automatic test_random();
    logic [9:0] expQ [$];
    logic [9:0] exp;
    logic [9:0] held;
    logic       prevStall;
    prevStall = 1'b0;
    held = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (prevStall) begin
        total++;
        if ({n8OutValid, n8Ovf, n8Carry, n8Sum} !== {1'b1, held}) begin
          bad++; $display("[TB] FAIL rnd_hold: got v=%b %h want v=1 %h", n8OutValid, {n8Ovf, n8Carry, n8Sum}, held);
        end
      end
      if (cyc < 380) begin
        applyStimulus(exp);
        n8InValid  = ($urandom_range(0, 3) != 0);
        n8OutReady = ($urandom_range(0, 2) != 0);
      end else begin
        n8InValid  = 1'b0;
        n8OutReady = 1'b1;
      end
      #1;
      if (n8OutValid && n8OutReady) begin
        total++;
        if (expQ.size() == 0) begin
          bad++; $display("[TB] FAIL rnd_unexpected: got %h want no result", {n8Ovf, n8Carry, n8Sum});
        end else begin
          if ({n8Ovf, n8Carry, n8Sum} !== expQ[0]) begin
            bad++; $display("[TB] FAIL rnd_result: got %h want %h", {n8Ovf, n8Carry, n8Sum}, expQ[0]);
          end
          void'(expQ.pop_front());
        end
      end
      if (n8InValid && n8InReady) expQ.push_back(exp);
      prevStall = n8OutValid && !n8OutReady;
      held = {n8Ovf, n8Carry, n8Sum};
    end
    total++;
    if (expQ.size() != 0) begin
      bad++; $display("[TB] FAIL rnd_drain: got %0d results outstanding want 0", expQ.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    test_wide();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
